dmem_bytelane: RTL and testbench
================================

# dmem_bytelane

Parametrised successor to the processor's word-only data memory. It adds byte, halfword and word loads and stores with per-byte write lanes, sign or zero extension, registered reads with a valid strobe, and misalignment/illegal-access detection. An optional post-reset clearing sweep, with a ready handshake, is also available. It sits in the MEM stage between the ALU address output and the write-back mux.

## Interface
Parameters:
- `DM_ADDRESS`, 9: word-address bits; depth = 2**DM_ADDRESS words.
- `DATA_W`, 32: word width; must be 32 or 64.
- Derived (localparam, not overridable):
  - `NB` = DATA_W/8 byte lanes.
  - `OFF_W` = log2(NB).

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request this cycle.
- `MemRead`  in  1  load request (controller).
- `MemWrite`  in  1  store request (controller).
- `funct3`  in  3  access type:
  - [1:0] = log2(size in bytes): 0=B, 1=H, 2=W, 3=D.
  - [2] = zero-extend on load (LBU/LHU/LWU); ignored on stores.
- `a`  in  DM_ADDRESS+OFF_W  byte address (LSBs of ALU output).
- `wd`  in  DATA_W  store data, right-aligned.
- `rd`  out  DATA_W  load data, right-aligned and extended.
- `rd_valid`  out  1  `rd` valid this cycle.
- `err`  out  1  previous accepted request was rejected.

## Operation
- Accept: a request is accepted when `req_valid && req_ready && (MemRead || MemWrite)`. At most one request per cycle.
- Request fields: word index = `a[DM_ADDRESS+OFF_W-1:OFF_W]`; byte offset `off` = `a[OFF_W-1:0]`; size S = 2**funct3[1:0] bytes.
- Illegal request: any of the following makes the request illegal:
  - `off % S != 0` (misaligned);
  - S > NB;
  - `MemRead && MemWrite` both high.
- Illegal request response:
  - no memory update;
  - `rd_valid` stays 0;
  - `err` = 1 for one cycle;
  - `rd` holds its previous value.
- Store:
  - Write byte lanes `off .. off+S-1` of the addressed word with `wd[8*S-1:0]`, lowest byte into lane `off`.
  - All other lanes are unchanged.
- Load:
  - Read the full word, then select bytes `off .. off+S-1`.
  - Sign-extend from bit 8*S-1 when funct3[2]=0; zero-extend when it is 1.
  - When S = NB, no extension is applied.
- FSM states:
  - **INIT**: clearing sweep; `req_ready`=0; an internal counter writes 0 to word `cnt` each cycle. Exits to **IDLE** after word 2**DM_ADDRESS-1 is written.
  - **IDLE**: `req_ready`=1; services requests.
- Reset (any cycle, including mid-sweep or with a load in flight):
  - state goes to INIT with `cnt`=0;
  - pending response is discarded;
  - outputs return to reset values.
  - Memory contents are not otherwise touched by reset.
- Reset values:
  - `req_ready`=0
  - `rd`=0
  - `rd_valid`=0
  - `err`=0
- Requests presented while `req_ready`=0 are ignored, not queued.

## Timing
- Request sampled at rising edge E.
- `rd`/`rd_valid`/`err` are registered at E and visible for the cycle after E.
- Load latency = 1 cycle.
- `rd_valid` and `err` are single-cycle pulses unless another request is accepted at E+1.
- Back-to-back loads every cycle are supported at full throughput.
- Store accepted at E updates memory at E. A load of the same word accepted at E+1 returns the new data (no stale read).
- Stores produce no response; `rd_valid`=0 in the following cycle.
- INIT sweep: first `rst`=0 edge R clears word 0; edge R+2**DM_ADDRESS-1 clears the last word.
  - `req_ready` = 1 after edge R+2**DM_ADDRESS-1.
  - Sweep duration is 512 cycles at default.

## Configuration
- Macro: `DMEM_INIT_SWEEP_EN`.
- Defined: INIT sweep as above. Memory reads 0 everywhere after reset.
- Undefined:
  - INIT state removed; reset goes directly to IDLE;
  - `req_ready` = 1 after the first edge with `rst`=0;
  - memory contents undefined until written.
- All other behaviour is identical in both builds.

## Test plan
- Reset/sweep (macro defined, DM_ADDRESS=4): `rst` for 2 cycles, then release → `req_ready` low for exactly 16 cycles. LW from every word returns 0x00000000 with `rd_valid` 1 cycle after each request. Reassert `rst` mid-sweep → sweep restarts from word 0.
- Byte-lane stores: SW 0x11223344 @0x10, then SB 0xAA @0x11, then SH 0xBEEF @0x12 → LW @0x10 returns 0xBEEFAA44.
- Extension: with word @0x10 = 0xBEEFAA44, issue:
  - LB @0x11 → 0xFFFFFFAA
  - LBU @0x11 → 0x000000AA
  - LH @0x12 → 0xFFFFBEEF
  - LHU @0x12 → 0x0000BEEF
- Illegal accesses:
  - LW @0x12, SH @0x13, LD with DATA_W=32, and MemRead=MemWrite=1 → each gives `err`=1 for one cycle and `rd_valid`=0;
  - a following LW @0x10 still returns 0xBEEFAA44.
- Throughput/RAW: SW 0xCAFEF00D @0x20 at edge E, LW @0x20 at E+1, LW @0x10 at E+2 → consecutive `rd_valid` pulses with 0xCAFEF00D then 0xBEEFAA44. Assert `rst` on the cycle after the final load → `rd_valid` drops to 0 and `rd`=0.

Source files
------------

// File: rtl/dmem_bytelane.sv
// rtl/dmem_bytelane.sv - byte-lane data memory with registered, extended loads and access checking
// DMEM_INIT_SWEEP_EN: when defined, memory is cleared by a post-reset sweep before req_ready rises.
module dmem_bytelane #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  localparam int NB        = DATA_W / 8,
  localparam int OFF_W     = $clog2(DATA_W / 8)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        MemRead,
  input  logic                        MemWrite,
  input  logic [2:0]                  funct3,
  input  logic [DM_ADDRESS+OFF_W-1:0] a,
  input  logic [DATA_W-1:0]           wd,
  output logic [DATA_W-1:0]           rd,
  output logic                        rd_valid,
  output logic                        err
);

  localparam int DEPTH = 2 ** DM_ADDRESS;
  localparam int SW    = $clog2(DATA_W);

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DM_ADDRESS-1:0] widx;
  logic [OFF_W-1:0]      off;
  logic [1:0]            sz;
  logic [3:0]            smask;
  logic                  misaligned, too_big, illegal, accept, wr_en, rd_en;
  logic [NB-1:0]         be;
  logic [DATA_W-1:0]     wdata, shifted, kmask, ldata;
  logic [6:0]            nbits;
  logic [SW-1:0]         sidx;
  logic                  ext;
  logic                  rdy;

  assign widx  = a[DM_ADDRESS+OFF_W-1:OFF_W];
  assign off   = a[OFF_W-1:0];
  assign sz    = funct3[1:0];
  assign smask = (4'd1 << sz) - 4'd1;

  assign misaligned = |(4'(off) & smask);
  assign too_big    = int'(sz) > OFF_W;
  assign illegal    = misaligned || too_big || (MemRead && MemWrite);
  assign accept     = req_valid && req_ready && (MemRead || MemWrite) && !rst;
  assign wr_en      = accept && !illegal && MemWrite;
  assign rd_en      = accept && !illegal && MemRead;
  assign req_ready  = rdy;

  always_comb begin
    be = '0;
    for (int i = 0; i < NB; i++)
      be[i] = (i >= int'(off)) && (i < int'(off) + (1 << sz));
  end

  assign wdata = wd << {off, 3'b000};

  // Load path: right-align the selected bytes, then mask to the access width and extend above it.
  // A full-width access shifts the all-ones mask out entirely, so no extension is applied.
  assign shifted = mem[widx] >> {off, 3'b000};
  assign nbits   = 7'd8 << sz;
  assign kmask   = ~({DATA_W{1'b1}} << nbits);
  assign sidx    = SW'(nbits - 7'd1);
  assign ext     = !funct3[2] && shifted[sidx];
  assign ldata   = (shifted & kmask) | ({DATA_W{ext}} & ~kmask);

`ifdef DMEM_INIT_SWEEP_EN
  typedef enum logic {INIT, IDLE} state_t;
  state_t                state, state_nxt;
  logic [DM_ADDRESS-1:0] cnt;
  logic                  sweep_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    sweep_we  = 1'b0;
    case (state)
      INIT: begin
        sweep_we = !rst;
        if (cnt == {DM_ADDRESS{1'b1}}) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
`ifdef DMEM_INIT_SWEEP_EN
    if (sweep_we) mem[cnt] <= '0;
`endif
    if (wr_en) begin
      for (int i = 0; i < NB; i++)
        if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd       <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
      rdy      <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      err      <= accept && illegal;
      if (rd_en) rd <= ldata;
`ifdef DMEM_INIT_SWEEP_EN
      rdy <= (state_nxt == IDLE);
`else
      rdy <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_bytelane.sv
// tb/tb_dmem_bytelane.sv - directed bench for dmem_bytelane with a byte-array reference model
module tb_dmem_bytelane;

  localparam int DMA = 4;
`ifdef DMEM_INIT_SWEEP_EN
  localparam int SWEEP = 16;
`else
  localparam int SWEEP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [5:0]  a = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic        rd_valid, err;

  int checks = 0;
  int errors = 0;

  dmem_bytelane #(.DM_ADDRESS(DMA), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .MemRead(mem_read), .MemWrite(mem_write), .funct3(funct3), .a(a),
    .wd(wd), .rd(rd), .rd_valid(rd_valid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory as 64 bytes, responses derived from size/offset arithmetic.
  logic [7:0]  mb [64];
  bit          known [64];
  int          sweep_left = 0;
  bit          checking = 0;
  bit          exp_ready = 0, exp_valid = 0, exp_err = 0, rd_known = 1;
  logic [31:0] exp_rd = '0;

  always @(posedge clk) begin : model
    int s, off, base, ai;
    longint v;
    bit k, acc;
    if (rst) begin
      checking   = 1;
      exp_ready  = 0; exp_valid = 0; exp_err = 0;
      exp_rd     = '0; rd_known = 1;
      sweep_left = SWEEP;
    end else begin
      acc = req_valid && exp_ready && (mem_read || mem_write);
      exp_valid = 0; exp_err = 0;
      if (acc) begin
        s = 1 << funct3[1:0];
        ai = int'(a); off = ai % 4; base = ai - off;
        if ((off % s) != 0 || s > 4 || (mem_read && mem_write)) exp_err = 1;
        else if (mem_write) begin
          for (int i = 0; i < s; i++) begin
            mb[base + off + i] = 8'(wd >> (8 * i));
            known[base + off + i] = 1;
          end
        end else begin
          v = 0; k = 1;
          for (int i = 0; i < s; i++) begin
            v = v | (longint'(mb[base + off + i]) << (8 * i));
            k = k && known[base + off + i];
          end
          if (!funct3[2] && s < 4 && ((v >> (8 * s - 1)) & 1) == 1)
            v = v | ~((64'd1 << (8 * s)) - 1);
          exp_rd = v[31:0]; rd_known = k; exp_valid = 1;
        end
      end
      if (sweep_left > 0) begin
        for (int i = 0; i < 4; i++) begin
          mb[(SWEEP - sweep_left) * 4 + i] = 8'h00;
          known[(SWEEP - sweep_left) * 4 + i] = 1;
        end
        sweep_left--;
      end
      exp_ready = (sweep_left == 0);
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("cmp req_ready", 32'(req_ready), 32'(exp_ready));
      chk("cmp rd_valid", 32'(rd_valid), 32'(exp_valid));
      chk("cmp err", 32'(err), 32'(exp_err));
      if (rd_known) chk("cmp rd", rd, exp_rd);
    end
  end

  task automatic drive(input bit r, input bit w, input logic [2:0] f,
                       input logic [5:0] ad, input logic [31:0] d);
    @(posedge clk); #1;
    req_valid = 1; mem_read = r; mem_write = w; funct3 = f; a = ad; wd = d;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    req_valid = 0; mem_read = 0; mem_write = 0;
  endtask

  task automatic op(input bit r, input bit w, input logic [2:0] f,
                    input logic [5:0] ad, input logic [31:0] d);
    drive(r, w, f, ad, d);
    idle();
  endtask

  task automatic load_chk(input logic [2:0] f, input logic [5:0] ad,
                          input logic [31:0] exp, input string name);
    op(1, 0, f, ad, '0);
    @(negedge clk);
    chk({name, " rd"}, rd, exp);
    chk({name, " rd_valid"}, 32'(rd_valid), 32'd1);
  endtask

  task automatic illegal_chk(input bit r, input bit w, input logic [2:0] f,
                             input logic [5:0] ad, input string name);
    op(r, w, f, ad, 32'h5555_5555);
    @(negedge clk);
    chk({name, " err"}, 32'(err), 32'd1);
    chk({name, " rd_valid"}, 32'(rd_valid), 32'd0);
  endtask

  task automatic reset_and_count(input string name);
    int lows;
    @(posedge clk); #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    lows = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (req_ready === 1'b1) break;
      lows++;
    end
    chk(name, lows, (SWEEP > 0) ? SWEEP : 1);
  endtask

  initial begin
    reset_and_count("ready_low_cycles");
    // Reassert reset partway into the sweep; the sweep must restart from word 0.
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    repeat (5) @(posedge clk);
    reset_and_count("ready_low_after_mid_reset");

    if (SWEEP > 0)
      for (int w = 0; w < 16; w++) load_chk(3'b010, 6'(w * 4), 32'h0, "sweep_zero");

    op(0, 1, 3'b010, 6'h10, 32'h1122_3344);
    @(negedge clk);
    chk("store no rd_valid", 32'(rd_valid), 32'd0);
    op(0, 1, 3'b000, 6'h11, 32'h0000_00AA);
    op(0, 1, 3'b001, 6'h12, 32'h0000_BEEF);
    load_chk(3'b010, 6'h10, 32'hBEEF_AA44, "lw_lanes");

    load_chk(3'b000, 6'h11, 32'hFFFF_FFAA, "lb");
    load_chk(3'b100, 6'h11, 32'h0000_00AA, "lbu");
    load_chk(3'b001, 6'h12, 32'hFFFF_BEEF, "lh");
    load_chk(3'b101, 6'h12, 32'h0000_BEEF, "lhu");
    load_chk(3'b000, 6'h10, 32'h0000_0044, "lb_pos");

    illegal_chk(1, 0, 3'b010, 6'h12, "ill_lw_misaligned");
    illegal_chk(0, 1, 3'b001, 6'h13, "ill_sh_misaligned");
    illegal_chk(1, 0, 3'b011, 6'h10, "ill_ld");
    illegal_chk(1, 1, 3'b010, 6'h10, "ill_rw");
    load_chk(3'b010, 6'h10, 32'hBEEF_AA44, "lw_after_illegal");

    drive(0, 1, 3'b010, 6'h20, 32'hCAFE_F00D);
    drive(1, 0, 3'b010, 6'h20, '0);
    @(negedge clk);
    chk("raw store no rd_valid", 32'(rd_valid), 32'd0);
    drive(1, 0, 3'b010, 6'h10, '0);
    @(negedge clk);
    chk("raw rd", rd, 32'hCAFE_F00D);
    chk("raw rd_valid", 32'(rd_valid), 32'd1);
    @(posedge clk); #1;
    req_valid = 0; mem_read = 0; mem_write = 0; rst = 1;
    @(negedge clk);
    chk("b2b rd", rd, 32'hBEEF_AA44);
    chk("b2b rd_valid", 32'(rd_valid), 32'd1);
    @(negedge clk);
    chk("reset rd", rd, 32'h0);
    chk("reset rd_valid", 32'(rd_valid), 32'd0);
    chk("reset req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1 rst = 0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
